// File: rtl/fetch_controller_pkg.sv
// Shared types, state encodings and address-legality helper for the fetch controller.
// Optional feature macro used by the top: FETCH_PERF_CNT_EN.
`ifndef NOP_INSTRUCTION
`define NOP_INSTRUCTION 32'h0000_0013
`endif

package fetch_controller_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_RUN   = 2'd1,
      FETCH_FAULT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR        = `NOP_INSTRUCTION;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef struct packed {
      fetch_state_e state;
      logic [7:0]   count;
   } fetch_dbg_t;

   // Word aligned and inside the instruction memory.
   function automatic logic pc_legal(input logic [31:0] pc, input int unsigned mem_words);
      logic [63:0] limit;
      limit = 64'(mem_words) << 2;
      return (pc[1:0] == 2'b00) && ({32'h0, pc} < limit);
   endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-side bus: instruction memory address/data plus the decode handshake.
// Handshake: a head transfers on a rising edge where instr_valid_o && instr_ready_i;
// instr_valid_o never depends combinationally on instr_ready_i.
interface fetch_controller_if;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_instr_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        instr_ready_i;

   modport master (
      output imem_addr_o,
      input  imem_instr_i,
      output instr_valid_o,
      output instr_o,
      output pc_o,
      input  instr_ready_i
   );

   modport slave (
      input  imem_addr_o,
      output imem_instr_i,
      input  instr_valid_o,
      input  instr_o,
      input  pc_o,
      output instr_ready_i
   );
endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries with flush; head is read straight from storage.
module fetch_queue
   import fetch_controller_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  fetch_entry_t push_data_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output fetch_entry_t head_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [PW:0]  count_o
);

   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   fetch_entry_t    mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [PW:0]     count_q;
   logic            do_push;
   logic            do_pop;

   assign full_o  = (count_q == DEPTH_C);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A push into a full queue is legal only when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PW+1)'(1);
            2'b01:   count_q <= count_q - (PW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// Fetch PC sequencer with redirect flush and sticky fault on illegal fetch addresses.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 fetch_en_i,
   input  logic                 redirect_valid_i,
   input  logic [31:0]          redirect_pc_i,
   fetch_controller_if.master   bus,
   output logic                 fault_o,
   output logic [31:0]          fault_pc_o,
   output fetch_dbg_t           dbg_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]          perf_fetch_cnt_o,
   output logic [31:0]          perf_stall_cnt_o
`endif
);

   localparam int PW = $clog2(DEPTH);

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic          fault_q, fault_d;
   logic [31:0]   fault_pc_q, fault_pc_d;

   fetch_entry_t  head;
   logic          q_full;
   logic          q_empty;
   logic [PW:0]   q_count;
   logic          pc_ok;
   logic          tgt_ok;
   logic          fetch_req;
   logic          push;
   logic          pop;

   assign pc_ok     = pc_legal(pc_q, MEM_WORDS);
   assign tgt_ok    = pc_legal(redirect_pc_i, MEM_WORDS);
   assign fetch_req = (state_q == FETCH_RUN) && fetch_en_i && !redirect_valid_i;
   assign pop       = !q_empty && bus.instr_ready_i && !redirect_valid_i;
   assign push      = fetch_req && pc_ok && (!q_full || pop);

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i ('{pc: pc_q, instr: bus.imem_instr_i}),
      .pop_i       (pop),
      .flush_i     (redirect_valid_i),
      .head_o      (head),
      .full_o      (q_full),
      .empty_o     (q_empty),
      .count_o     (q_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH_IDLE;
         pc_q       <= RESET_PC;
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;
      if (redirect_valid_i) begin
         pc_d = redirect_pc_i;
         if (tgt_ok) begin
            fault_d = 1'b0;
            state_d = fetch_en_i ? FETCH_RUN : FETCH_IDLE;
         end else if (state_q == FETCH_FAULT) begin
            fault_pc_d = redirect_pc_i;
         end else begin
            // Illegal target: the fault is raised when the fetch is attempted next cycle.
            state_d = fetch_en_i ? FETCH_RUN : FETCH_IDLE;
         end
      end else begin
         case (state_q)
            FETCH_IDLE: begin
               if (fetch_en_i) state_d = FETCH_RUN;
            end
            FETCH_RUN: begin
               if (!fetch_en_i) begin
                  state_d = FETCH_IDLE;
               end else if (!pc_ok) begin
                  state_d    = FETCH_FAULT;
                  fault_d    = 1'b1;
                  fault_pc_d = pc_q;
               end else if (push) begin
                  pc_d = pc_q + 32'd4;
               end
            end
            FETCH_FAULT: begin
               state_d = FETCH_FAULT;
            end
            default: state_d = FETCH_IDLE;
         endcase
      end
   end

   assign bus.imem_addr_o   = pc_q;
   assign bus.instr_valid_o = !q_empty;
   assign bus.instr_o       = q_empty ? NOP_INSTR : head.instr;
   assign bus.pc_o          = q_empty ? 32'h0 : head.pc;
   assign fault_o           = fault_q;
   assign fault_pc_o        = fault_pc_q;
   assign dbg_o             = '{state: state_q, count: 8'(q_count)};

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if (push) perf_fetch_q <= perf_fetch_q + 32'd1;
         if ((state_q == FETCH_RUN) && q_full && !pop) perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_fetch_cnt_o = perf_fetch_q;
   assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: scoreboard of expected {pc, instr} heads,
// immediate-assertion checks, and a pass/total summary.
module tb_fetch_controller;
   import fetch_controller_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fault;
   logic [31:0] fault_pc;
   fetch_dbg_t  dbg;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch;
   logic [31:0] perf_stall;
`endif

   fetch_controller_if bus ();

   fetch_controller dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .fetch_en_i       (fetch_en),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .bus              (bus),
      .fault_o          (fault),
      .fault_pc_o       (fault_pc),
      .dbg_o            (dbg)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt_o (perf_fetch),
      .perf_stall_cnt_o (perf_stall)
`endif
   );

   // Instruction memory: word k holds k.
   assign bus.imem_instr_i = (bus.imem_addr_o < 32'h1000) ? {2'b00, bus.imem_addr_o[31:2]} : 32'hDEAD_BEEF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [63:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_q.push_back({pc, 2'b00, pc[31:2]});
   endtask

   // Called at a negedge; accepts n heads and compares each against the scoreboard.
   task automatic take(input int n, output int gaps);
      int got;
      int cyc;
      logic [63:0] e;
      got  = 0;
      cyc  = 0;
      gaps = 0;
      bus.instr_ready_i = 1'b1;
      while (got < n && cyc < 50) begin
         if (bus.instr_valid_o) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            chk("head_pc", bus.pc_o, e[63:32]);
            chk("head_instr", bus.instr_o, e[31:0]);
            got++;
         end else if (got > 0) begin
            gaps++;
         end
         cyc++;
         @(negedge clk);
      end
      bus.instr_ready_i = 1'b0;
      chk("take_count", 32'(got), 32'(n));
   endtask

   task automatic do_reset();
      rst_n             = 1'b0;
      fetch_en          = 1'b0;
      redirect_valid    = 1'b0;
      bus.instr_ready_i = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n    = 1'b1;
      fetch_en = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int gaps;
      rst_n             = 1'b0;
      fetch_en          = 1'b0;
      redirect_valid    = 1'b0;
      redirect_pc       = 32'h0;
      bus.instr_ready_i = 1'b0;
      repeat (2) @(negedge clk);

      // Reset values
      chk1("rst_valid", bus.instr_valid_o, 1'b0);
      chk("rst_instr", bus.instr_o, NOP_INSTR);
      chk("rst_pc", bus.pc_o, 32'h0);
      chk1("rst_fault", fault, 1'b0);
      chk("rst_fault_pc", fault_pc, 32'h0);
      chk("rst_addr", bus.imem_addr_o, 32'h0);
      chk("rst_state", 32'(dbg.state), 32'(FETCH_IDLE));

      // 1: in-order stream and one-cycle fetch latency
      rst_n    = 1'b1;
      fetch_en = 1'b1;
      @(negedge clk);
      chk("t1_state", 32'(dbg.state), 32'(FETCH_RUN));
      chk("t1_addr0", bus.imem_addr_o, 32'h0);
      chk1("t1_not_yet_valid", bus.instr_valid_o, 1'b0);
      @(negedge clk);
      chk1("t1_first_valid", bus.instr_valid_o, 1'b1);
      chk("t1_addr1", bus.imem_addr_o, 32'h4);
      push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
      take(3, gaps);

      // 2: backpressure fills exactly DEPTH entries, then drains without gaps
      do_reset();
      repeat (10) @(negedge clk);
      chk("t2_addr_stall", bus.imem_addr_o, 32'h10);
      chk("t2_count", 32'(dbg.count), 32'd4);
      chk1("t2_valid", bus.instr_valid_o, 1'b1);
`ifdef FETCH_PERF_CNT_EN
      chk("t2_perf_fetch", perf_fetch, 32'd4);
      chk("t2_perf_stall", perf_stall, 32'd5);
`endif
      for (int i = 0; i < 6; i++) push_exp(32'(i * 4));
      take(6, gaps);
      chk("t2_gaps", 32'(gaps), 32'd0);

      // 3: redirect flushes three queued entries; same-cycle ready pops nothing
      do_reset();
      repeat (4) @(negedge clk);
      chk("t3_count", 32'(dbg.count), 32'd3);
      chk("t3_head", bus.pc_o, 32'h0);
      redirect_valid    = 1'b1;
      redirect_pc       = 32'h100;
      bus.instr_ready_i = 1'b1;
      @(negedge clk);
      redirect_valid    = 1'b0;
      bus.instr_ready_i = 1'b0;
      chk1("t3_flushed", bus.instr_valid_o, 1'b0);
      chk("t3_addr", bus.imem_addr_o, 32'h100);
      @(negedge clk);
      chk1("t3_target_valid", bus.instr_valid_o, 1'b1);
      push_exp(32'h100); push_exp(32'h104);
      take(2, gaps);

      // 4: misaligned redirect faults; legal redirect clears and resumes
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("t4_addr", bus.imem_addr_o, 32'h102);
      @(negedge clk);
      chk1("t4_fault", fault, 1'b1);
      chk("t4_fault_pc", fault_pc, 32'h102);
      chk1("t4_valid", bus.instr_valid_o, 1'b0);
      chk("t4_state", 32'(dbg.state), 32'(FETCH_FAULT));
      repeat (2) @(negedge clk);
      chk("t4_addr_hold", bus.imem_addr_o, 32'h102);
      chk1("t4_still_empty", bus.instr_valid_o, 1'b0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk1("t4_fault_cleared", fault, 1'b0);
      chk("t4_state_run", 32'(dbg.state), 32'(FETCH_RUN));
      push_exp(32'h0); push_exp(32'h4);
      take(2, gaps);

      // 5: run off the end of memory
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFF8;
      @(negedge clk);
      redirect_valid = 1'b0;
      push_exp(32'hFF8); push_exp(32'hFFC);
      take(2, gaps);
      chk1("t5_fault", fault, 1'b1);
      chk("t5_fault_pc", fault_pc, 32'h1000);
      repeat (3) @(negedge clk);
      chk1("t5_no_enqueue", bus.instr_valid_o, 1'b0);
      chk("t5_addr_hold", bus.imem_addr_o, 32'h1000);

      // 6: async reset mid-stall with a full queue
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      @(negedge clk);
      redirect_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("t6_full", 32'(dbg.count), 32'd4);
      #2 rst_n = 1'b0;
      #1;
      chk1("t6_valid", bus.instr_valid_o, 1'b0);
      chk("t6_instr", bus.instr_o, NOP_INSTR);
      chk("t6_pc", bus.pc_o, 32'h0);
      chk("t6_addr", bus.imem_addr_o, 32'h0);
      chk("t6_fault_pc", fault_pc, 32'h0);
      chk("t6_count", 32'(dbg.count), 32'd0);
      chk("t6_state", 32'(dbg.state), 32'(FETCH_IDLE));
`ifdef FETCH_PERF_CNT_EN
      chk("t6_perf_fetch", perf_fetch, 32'd0);
      chk("t6_perf_stall", perf_stall, 32'd0);
`endif
      @(negedge clk);
      rst_n    = 1'b1;
      fetch_en = 1'b1;

      // 7: redirect together with fetch disable
      repeat (3) @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      fetch_en       = 1'b0;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("t7_state", 32'(dbg.state), 32'(FETCH_IDLE));
      chk("t7_addr", bus.imem_addr_o, 32'h40);
      chk1("t7_flushed", bus.instr_valid_o, 1'b0);
      repeat (3) @(negedge clk);
      chk("t7_addr_idle", bus.imem_addr_o, 32'h40);
      fetch_en = 1'b1;
      push_exp(32'h40); push_exp(32'h44);
      take(2, gaps);
      chk("sb_leftover", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences instruction fetch from the combinational, word-organised instruction memory (4 KB, 1024 words) into a small prefetch queue feeding the decode stage. It owns the fetch PC, issues one word address per cycle, and captures the returned word together with its PC. It also handles branch/jump redirects by flushing, and enters a sticky fault state on misaligned or out-of-range fetch addresses instead of silently fetching NOPs.

Parameters:
DEPTH, 4, prefetch queue entries (power of two, ≥2)
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
MEM_WORDS, 1024, instruction memory size in words; valid byte range 0 .. MEM_WORDS*4-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_en_i  in  1  fetch enable; low = stop issuing new fetches
redirect_valid_i  in  1  branch/jump/exception redirect request
redirect_pc_i  in  32  redirect target byte address
imem_addr_o  out  32  byte address to instruction memory (always = fetch PC)
imem_instr_i  in  32  combinational read data from instruction memory
instr_valid_o  out  1  queue head valid
instr_o  out  32  queue head instruction
pc_o  out  32  queue head PC
instr_ready_i  in  1  decode accepts the head this cycle
fault_o  out  1  fetch fault sticky flag
fault_pc_o  out  32  offending fetch address

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC, queue empty, state=IDLE, instr_valid_o=0, instr_o=`NOP_INSTRUCTION, pc_o=0, fault_o=0, fault_pc_o=0. imem_addr_o=RESET_PC.
- FSM states:
  - IDLE: enters FETCH when fetch_en_i=1.
  - FETCH: returns to IDLE when fetch_en_i=0; already-queued entries remain and continue to drain.
  - FAULT: exits only via a legal redirect.
- Enqueue in FETCH when count<DEPTH, or count=DEPTH with a dequeue in the same cycle.
  - Enqueue: {imem_instr_i, fetch_pc} written at the clock edge; fetch_pc += 4.
  - Latency: address issued in cycle N → instr_valid_o=1 in cycle N+1 (queue previously empty).
- Dequeue: instr_valid_o && instr_ready_i. Head outputs are registered from the queue. instr_o shows `NOP_INSTRUCTION when the queue is empty.
- Full: fetch_pc holds, with no enqueue and no address advance. Empty: instr_valid_o=0.
- Pointer wrap-around: pointers are log2(DEPTH) bits, and count is a separate log2(DEPTH)+1-bit field.
- Redirect (highest priority):
  - Queue flushed and same-cycle enqueue/dequeue discarded.
  - fetch_pc=redirect_pc_i; the first fetch from the target occurs in the next cycle.
  - Clears fault_o if the target is legal.
- Fault on misaligned address:
  - Trigger: fetch_pc[1:0]≠0 (only reachable via redirect) when fetch would occur.
  - Action: state=FAULT, fault_o=1, fault_pc_o=fetch_pc, no enqueue; entries already queued still drain.
- Fault on out-of-range address:
  - Trigger: fetch_pc ≥ MEM_WORDS*4 when fetch would occur.
  - Action: same as the misaligned case.
- Redirect to an illegal target: FAULT is entered on the next cycle with fault_pc_o=target.
- Simultaneous redirect and fetch_en_i=0: the PC is updated, state goes to IDLE, and the queue is flushed.
- Reset asserted mid-operation: all state is cleared immediately, with no partial entries retained.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined:
  - Adds outputs perf_fetch_cnt_o[31:0], counting enqueued instructions.
  - Adds perf_stall_cnt_o[31:0], counting cycles in FETCH where the queue is full with no dequeue.
  - Both reset to 0 and wrap at 2^32. Redirect does not clear them.
- Undefined: the ports and counters are absent, and functional behaviour is identical.

Decomposition:
- Shared include (defines.v):
  - `NOP_INSTRUCTION (already present).
  - FSM state encodings FETCH_IDLE/FETCH_RUN/FETCH_FAULT (2 bits).
  - RESET_PC default.
- Sub-module fetch_queue:
  - Parameterised DEPTH FIFO of {pc, instr} (64 bits).
  - Ports: push, pop, flush, full, empty, count.
  - fetch_controller holds the FSM, PC, range check and counters.

Test Plan:
1. Reset release, fetch_en_i=1, instr_ready_i=1, memory word k=k → pc_o/instr_o sequence 0x0/0,0x4/1,0x8/2; first instr_valid_o one cycle after first fetch.
2. instr_ready_i=0 for 10 cycles → exactly DEPTH=4 entries queued, imem_addr_o stalls at 0x10; release → entries 0x0..0xC out in order, then 0x10 follows without gap.
3. Redirect to 0x100 while 3 entries are queued → next valid head is pc 0x100 with no stale entry; a same-cycle ready dequeues nothing.
4. Redirect to 0x102 → fault_o=1, fault_pc_o=0x102, instr_valid_o=0. Redirect to 0x0 → fault_o=0, fetching resumes.
5. Sequential fetch to 0xFFC then 0x1000 → word 0x3FF delivered, then fault_o=1, fault_pc_o=0x1000, no further enqueue.
6. rst_n pulsed low asynchronously mid-stall with full queue → outputs return to reset values before the next clock edge; with FETCH_PERF_CNT_EN, counters read 0.
